// File: rtl/debug_dump_reader_if.sv
// Signals between the dump reader, the show-ahead debug byte FIFO and the UART transmitter.
// The FIFO, UART and control side drive the master modport; the reader uses the slave modport.
interface debug_dump_reader_if #(
    parameter int B = 8
);
    logic         start;
    logic         abort;
    logic         fifo_empty;
    logic [B-1:0] fifo_r_data;
    logic         fifo_rd;
    logic         tx_start;
    logic [B-1:0] tx_data;
    logic         tx_done_tick;
    logic         busy;
    logic         done_tick;
    logic [7:0]   byte_count;
    logic [2:0]   state_dbg;

    // Handshakes are one-cycle strobes with no backpressure: fifo_rd pops the head only while
    // fifo_empty=0, tx_start launches the byte on tx_data, and tx_done_tick retires that byte.
    modport master (
        output start, abort, fifo_empty, fifo_r_data, tx_done_tick,
        input  fifo_rd, tx_start, tx_data, busy, done_tick, byte_count, state_dbg
    );

    modport slave (
        input  start, abort, fifo_empty, fifo_r_data, tx_done_tick,
        output fifo_rd, tx_start, tx_data, busy, done_tick, byte_count, state_dbg
    );
endinterface

// File: rtl/debug_dump_reader.sv
// Pops debug bytes from the show-ahead FIFO and sends them to the UART TX as frames:
// one HEADER byte followed by N_BYTES payload bytes.
module debug_dump_reader #(
    parameter int           B       = 8,
    parameter int           N_BYTES = 4,
    parameter logic [B-1:0] HEADER  = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    debug_dump_reader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        FETCH,
        DATA_WAIT,
        DONE
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(N_BYTES);

    state_t       state_q, state_d;
    logic [B-1:0] tx_data_q, tx_data_d;
    logic         tx_start_q, tx_start_d;
    logic [7:0]   byte_count_q, byte_count_d;
    logic         fifo_rd_c;
    logic         done_tick_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            byte_count_q <= byte_count_d;
        end
    end

    // tx_start is registered so it lines up with the byte loaded into tx_data on the same edge;
    // only fifo_rd is combinational, and abort suppresses it.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        byte_count_d = byte_count_q;
        fifo_rd_c    = 1'b0;
        done_tick_c  = 1'b0;

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        tx_data_d    = HEADER;
                        tx_start_d   = 1'b1;
                        byte_count_d = '0;
                        state_d      = HDR;
                    end
                end
                HDR: state_d = HDR_WAIT;
                HDR_WAIT: begin
                    if (bus.tx_done_tick) state_d = FETCH;
                end
                FETCH: begin
                    if (!bus.fifo_empty) begin
                        fifo_rd_c  = 1'b1;
                        tx_data_d  = bus.fifo_r_data;
                        tx_start_d = 1'b1;
                        state_d    = DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (bus.tx_done_tick) begin
                        byte_count_d = byte_count_q + 8'd1;
                        state_d      = (byte_count_d == LAST_COUNT) ? DONE : FETCH;
                    end
                end
                DONE: begin
                    done_tick_c = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.fifo_rd    = fifo_rd_c;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done_tick  = done_tick_c;
    assign bus.byte_count = byte_count_q;
    assign bus.state_dbg  = state_q;

endmodule
